// File: rtl/dp_pkg.sv
// rtl/dp_pkg.sv - shared opcodes, FSM encoding and helpers for the multi-cycle datapath
// Purpose: ALU opcode constants, sequencing state encoding, link-register index helper.
// Ports: none (package).
package dp_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;
  localparam logic [3:0] OP_SRA = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
    S_MUL  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4
  } state_t;

  // The link register is always the highest-numbered register.
  function automatic int link_reg(input int nregs);
    return nregs - 1;
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - W-cycle unsigned shift-add multiplier
// Purpose: unsigned a*b producing a 2*W product, one partial-product step per cycle.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           load operands (accepted only when not busy)
//   a, b            multiplicand, multiplier (W bits)
//   busy            steps still outstanding
//   done            one-cycle pulse; product is final while done is high
//   product         2*W-bit result
module seq_multiplier #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int CW = $clog2(W) + 1;

  logic [CW-1:0] cnt;
  logic [W-1:0]  mcand;

  // One shift-add step: upper half accumulates the multiplicand when the
  // current multiplier LSB is set, then the whole register shifts right.
  function automatic logic [2*W-1:0] step(input logic [2*W-1:0] p, input logic [W-1:0] m);
    logic [W:0] sum;
    sum = {1'b0, p[2*W-1:W]} + (p[0] ? {1'b0, m} : {(W+1){1'b0}});
    return {sum, p[W-1:1]};
  endfunction

  assign busy = (cnt != '0);

  // The first step is folded into the load so that exactly W cycles elapse
  // from start to the cycle in which done is high with the final product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      mcand   <= '0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        mcand   <= a;
        product <= step({{W{1'b0}}, b}, a);
        cnt     <= CW'(W - 1);
      end else if (busy) begin
        product <= step(product, mcand);
        cnt     <= cnt - CW'(1);
        done    <= (cnt == CW'(1));
      end
    end
  end

endmodule

// File: rtl/multicycle_datapath.sv
// rtl/multicycle_datapath.sv - multi-cycle datapath: register bank, ALU, multiplier, memory port
// Purpose: executes one decoded operation per start, sequencing EXEC/MUL/MEM/WB, pulses done.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   start / ready / done           launch (IDLE only) / idle indicator / completion pulse
//   alu_control, reg_addr_1/2      opcode, source A / source B (alternative dest)
//   shift_amount, immediate_const  constants; const_src picks shift_amount (1) or sign-extended immediate (0)
//   alu_src, reg_write_en, regwrite_select, reg_data, reg_to_pc, npc   operand / write-back controls
//   mem_read, mem_write            load / store request (store wins)
//   mem_req/we/addr/wdata, mem_ack, mem_rdata   data memory handshake
//   alu_result, mult_high, *_flag, write_address registered results of the last operation
module multicycle_datapath
  import dp_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  parameter int IMM_W   = 21,
  parameter int R0_ZERO = 0,
  localparam int RAW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ready,
  output logic             done,
  input  logic [3:0]       alu_control,
  input  logic [RAW-1:0]   reg_addr_1,
  input  logic [RAW-1:0]   reg_addr_2,
  input  logic [4:0]       shift_amount,
  input  logic [IMM_W-1:0] immediate_const,
  input  logic             const_src,
  input  logic             alu_src,
  input  logic             reg_write_en,
  input  logic             regwrite_select,
  input  logic             reg_data,
  input  logic             reg_to_pc,
  input  logic [XLEN-1:0]  npc,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic             mem_req,
  output logic             mem_we,
  output logic [XLEN-1:0]  mem_addr,
  output logic [XLEN-1:0]  mem_wdata,
  input  logic             mem_ack,
  input  logic [XLEN-1:0]  mem_rdata,
  output logic [XLEN-1:0]  alu_result,
  output logic [XLEN-1:0]  mult_high,
  output logic             zero_flag,
  output logic             carry_flag,
  output logic             sign_flag,
  output logic             overflow_flag,
  output logic [RAW-1:0]   write_address
);

  localparam int SHW = $clog2(XLEN);
  localparam int MSB = XLEN - 1;

  state_t state, state_next;

  // Operation fields captured at start; the live inputs are ignored afterwards.
  logic [3:0]       op_q;
  logic [RAW-1:0]   a1_q, a2_q;
  logic [4:0]       sh_q;
  logic [IMM_W-1:0] imm_q;
  logic             const_src_q, alu_src_q, we_q, wsel_q, rsel_q, link_q, mr_q, mw_q;
  logic [XLEN-1:0]  npc_q;
  logic [XLEN-1:0]  load_q;

  logic [XLEN-1:0]  regs [NREGS];

  logic [XLEN-1:0]  rd_a, rd_b, const_val, op_a, op_b;
  logic [XLEN-1:0]  alu_res;
  logic             alu_c, alu_v;
  logic [XLEN:0]    sum_w, dif_w;
  logic [SHW-1:0]   shamt;

  logic             is_mul, is_mem, mul_start, mul_busy, mul_done;
  logic [2*XLEN-1:0] mul_prod;

  logic [RAW-1:0]   dest;
  logic [XLEN-1:0]  wb_data;
  logic             wr_en;

  assign is_mul = (op_q == OP_MUL);
  assign is_mem = mr_q | mw_q;

  // ---------------- operand fetch ----------------
  assign rd_a = ((R0_ZERO != 0) && (a1_q == '0)) ? '0 : regs[a1_q];
  assign rd_b = ((R0_ZERO != 0) && (a2_q == '0)) ? '0 : regs[a2_q];

  assign const_val = const_src_q ? XLEN'(sh_q) : XLEN'($signed(imm_q));
  assign op_a      = rd_a;
  assign op_b      = alu_src_q ? const_val : rd_b;
  assign shamt     = op_b[SHW-1:0];

  // ---------------- ALU ----------------
  // dif_w[XLEN] is the borrow, i.e. a < b unsigned.
  assign sum_w = {1'b0, op_a} + {1'b0, op_b};
  assign dif_w = {1'b0, op_a} - {1'b0, op_b};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res = sum_w[XLEN-1:0];
        alu_c   = sum_w[XLEN];
        alu_v   = (op_a[MSB] == op_b[MSB]) && (sum_w[MSB] != op_a[MSB]);
      end
      OP_SUB: begin
        alu_res = dif_w[XLEN-1:0];
        alu_c   = dif_w[XLEN];
        alu_v   = (op_a[MSB] != op_b[MSB]) && (dif_w[MSB] != op_a[MSB]);
      end
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_NOT:  alu_res = ~op_a;
      OP_SLL:  alu_res = op_a << shamt;
      OP_SRL:  alu_res = op_a >> shamt;
      OP_SRA:  alu_res = $signed(op_a) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  seq_multiplier #(.W(XLEN)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (op_a),
    .b       (op_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  // ---------------- write-back selection ----------------
  assign dest    = link_q ? RAW'(link_reg(NREGS)) : (wsel_q ? a2_q : a1_q);
  assign wb_data = link_q ? npc_q : (rsel_q ? alu_result : load_q);
  assign wr_en   = (state == S_WB) && (we_q || link_q) && !mw_q &&
                   !((R0_ZERO != 0) && (dest == '0));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start) state_next = S_EXEC;
      S_EXEC: state_next = is_mul ? S_MUL : (is_mem ? S_MEM : S_WB);
      S_MUL:  if (mul_done) state_next = is_mem ? S_MEM : S_WB;
      S_MEM:  if (mem_ack) state_next = S_WB;
      S_WB:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    ready     = (state == S_IDLE);
    mem_req   = (state == S_MEM);
    mul_start = (state == S_EXEC) && is_mul && !mul_busy;
  end

  assign mem_we    = mw_q;
  assign mem_addr  = alu_result;
  assign mem_wdata = rd_b;

  // ---------------- operation latch and results ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q <= '0; a1_q <= '0; a2_q <= '0; sh_q <= '0; imm_q <= '0;
      const_src_q <= 1'b0; alu_src_q <= 1'b0; we_q <= 1'b0; wsel_q <= 1'b0;
      rsel_q <= 1'b0; link_q <= 1'b0; mr_q <= 1'b0; mw_q <= 1'b0;
      npc_q <= '0; load_q <= '0;
      alu_result <= '0; mult_high <= '0;
      zero_flag <= 1'b0; carry_flag <= 1'b0; sign_flag <= 1'b0; overflow_flag <= 1'b0;
      write_address <= '0;
      done <= 1'b0;
    end else begin
      done <= (state == S_WB);
      if (state == S_IDLE && start) begin
        op_q <= alu_control; a1_q <= reg_addr_1; a2_q <= reg_addr_2;
        sh_q <= shift_amount; imm_q <= immediate_const;
        const_src_q <= const_src; alu_src_q <= alu_src; we_q <= reg_write_en;
        wsel_q <= regwrite_select; rsel_q <= reg_data; link_q <= reg_to_pc;
        mr_q <= mem_read; mw_q <= mem_write; npc_q <= npc;
      end
      if (state == S_EXEC && !is_mul) begin
        alu_result    <= alu_res;
        zero_flag     <= (alu_res == '0);
        carry_flag    <= alu_c;
        sign_flag     <= alu_res[MSB];
        overflow_flag <= alu_v;
      end
      if (state == S_MUL && mul_done) begin
        alu_result    <= mul_prod[XLEN-1:0];
        mult_high     <= mul_prod[2*XLEN-1:XLEN];
        zero_flag     <= (mul_prod[XLEN-1:0] == '0);
        carry_flag    <= (mul_prod[2*XLEN-1:XLEN] != '0);
        sign_flag     <= mul_prod[XLEN-1];
        overflow_flag <= 1'b0;
      end
      if (state == S_MEM && mem_ack && !mw_q) load_q <= mem_rdata;
      if (state == S_WB) write_address <= dest;
    end
  end

  // ---------------- register bank ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[dest] <= wb_data;
    end
  end

endmodule

// File: tb/tb_multicycle_datapath.sv
// tb/tb_multicycle_datapath.sv - self-checking bench for multicycle_datapath
module tb_multicycle_datapath;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        ready, done;
  logic [3:0]  alu_control = '0;
  logic [4:0]  reg_addr_1 = '0, reg_addr_2 = '0, shift_amount = '0;
  logic [20:0] immediate_const = '0;
  logic        const_src = 1'b0, alu_src = 1'b0, reg_write_en = 1'b0, regwrite_select = 1'b0;
  logic        reg_data = 1'b0, reg_to_pc = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic [31:0] npc = '0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] alu_result, mult_high;
  logic        zero_flag, carry_flag, sign_flag, overflow_flag;
  logic [4:0]  write_address;

  always #5 clk = ~clk;

  multicycle_datapath #(.XLEN(32), .NREGS(32), .IMM_W(21), .R0_ZERO(0)) dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready), .done(done),
    .alu_control(alu_control), .reg_addr_1(reg_addr_1), .reg_addr_2(reg_addr_2),
    .shift_amount(shift_amount), .immediate_const(immediate_const), .const_src(const_src),
    .alu_src(alu_src), .reg_write_en(reg_write_en), .regwrite_select(regwrite_select),
    .reg_data(reg_data), .reg_to_pc(reg_to_pc), .npc(npc),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .alu_result(alu_result), .mult_high(mult_high),
    .zero_flag(zero_flag), .carry_flag(carry_flag), .sign_flag(sign_flag),
    .overflow_flag(overflow_flag), .write_address(write_address)
  );

  typedef struct packed {
    logic [3:0]  op;
    logic [4:0]  a1, a2, sh;
    logic [20:0] imm;
    logic        src, csrc, we, wsel, rsel, link;
    logic [31:0] npc;
    logic        mr, mw;
  } op_t;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: architectural registers and the last upper product.
  logic [31:0] mreg [32];
  logic [31:0] m_hi;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic op_t mk_op(input logic [3:0] op, input logic [4:0] a1, input logic [4:0] a2,
                                input logic src, input logic [20:0] imm, input logic we, input logic wsel);
    op_t o;
    o = '0;
    o.op = op; o.a1 = a1; o.a2 = a2; o.src = src; o.imm = imm; o.we = we; o.wsel = wsel;
    o.rsel = 1'b1;
    return o;
  endfunction

  task automatic drive(input op_t o);
    alu_control = o.op; reg_addr_1 = o.a1; reg_addr_2 = o.a2; shift_amount = o.sh;
    immediate_const = o.imm; const_src = o.csrc; alu_src = o.src; reg_write_en = o.we;
    regwrite_select = o.wsel; reg_data = o.rsel; reg_to_pc = o.link; npc = o.npc;
    mem_read = o.mr; mem_write = o.mw;
  endtask

  // Garbage on every control input while busy: the DUT must use its latched copy.
  task automatic scramble();
    op_t g;
    g = op_t'({$urandom, $urandom, $urandom});
    drive(g);
    start     = 1'($urandom);
    mem_ack   = 1'($urandom);
    mem_rdata = $urandom;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    m_hi = '0;
  endtask

  task automatic run_op(input op_t o, input int ack_at, input logic [31:0] rd, output int lat);
    logic [31:0] a, b, bimm, res, hi, wbd;
    logic [63:0] p, wide;
    longint      sa, sb, sr;
    logic        cy, ov, is_mem, got;
    logic [4:0]  dest;
    int          mcnt, exp_lat;
    a    = mreg[o.a1];
    bimm = o.csrc ? {27'b0, o.sh} : {{11{o.imm[20]}}, o.imm};
    b    = o.src ? bimm : mreg[o.a2];
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    res = '0; hi = m_hi; cy = 1'b0; ov = 1'b0;
    case (o.op)
      4'd0: begin
        wide = {32'b0, a} + {32'b0, b}; res = wide[31:0]; cy = wide[32];
        sr = sa + sb; ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'd1: begin
        res = a - b; cy = (a < b);
        sr = sa - sb; ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'd2: res = a & b;
      4'd3: res = a | b;
      4'd4: res = a ^ b;
      4'd5: res = ~a;
      4'd6: res = a << b[4:0];
      4'd7: res = a >> b[4:0];
      4'd8: res = $signed(a) >>> b[4:0];
      4'd9: begin p = {32'b0, a} * {32'b0, b}; res = p[31:0]; hi = p[63:32]; cy = (hi != 0); end
      default: res = '0;
    endcase
    is_mem  = o.mr | o.mw;
    exp_lat = 3 + ((o.op == 4'd9) ? 32 : 0) + (is_mem ? ack_at : 0);
    dest    = o.link ? 5'd31 : (o.wsel ? o.a2 : o.a1);
    wbd     = o.link ? o.npc : (o.rsel ? res : rd);

    @(negedge clk);
    drive(o);
    start = 1'b1;
    lat = 0; mcnt = 0; got = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      lat++;
      scramble();
      if (lat == 1) check_eq("busy_ready", ready, 1'b0);
      if (done) begin
        got = 1'b1; start = 1'b0; mem_ack = 1'b0;
      end else if (mem_req) begin
        mcnt++;
        check_eq("mem_req_expected", is_mem, 1'b1);
        check_eq("mem_addr", mem_addr, res);
        check_eq("mem_we", mem_we, o.mw);
        if (o.mw) check_eq("mem_wdata", mem_wdata, mreg[o.a2]);
        mem_ack = (mcnt == ack_at);
        if (mcnt == ack_at) mem_rdata = rd;
      end
    end
    check_eq("done_seen", got, 1'b1);
    check_eq("latency", lat, exp_lat);
    check_eq("ready_at_done", ready, 1'b1);
    check_eq("alu_result", alu_result, res);
    check_eq("flags_zcso", {zero_flag, carry_flag, sign_flag, overflow_flag},
             {(res == 0), cy, res[31], ov});
    check_eq("mult_high", mult_high, hi);
    check_eq("write_address", write_address, dest);
    m_hi = hi;
    if ((o.we || o.link) && !o.mw) mreg[dest] = wbd;
  endtask

  op_t o;
  int  lat;

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst_ready", ready, 1'b1);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_mem_req", mem_req, 1'b0);
    check_eq("rst_alu_result", alu_result, 0);
    check_eq("rst_mult_high", mult_high, 0);
    check_eq("rst_flags", {zero_flag, carry_flag, sign_flag, overflow_flag}, 4'b0000);
    check_eq("rst_write_address", write_address, 0);
    rst = 1'b0;

    // r1 <- 0x7FFFFFFF by a load acked in the first MEM cycle
    o = mk_op(4'd0, 5'd0, 5'd1, 1'b1, 21'd0, 1'b1, 1'b1); o.mr = 1'b1; o.rsel = 1'b0;
    run_op(o, 1, 32'h7FFF_FFFF, lat);
    check_eq("load_fast_lat", lat, 4);
    // ADD r1 + 1: signed overflow into the sign bit
    run_op(mk_op(4'd0, 5'd1, 5'd0, 1'b1, 21'd1, 1'b0, 1'b0), 1, 0, lat);
    check_eq("add_ovf_result", alu_result, 32'h8000_0000);
    check_eq("add_ovf_flags", {zero_flag, carry_flag, sign_flag, overflow_flag}, 4'b0011);
    check_eq("add_lat", lat, 3);
    // r2 = 3, r3 = 5, then SUB both ways
    run_op(mk_op(4'd0, 5'd0, 5'd2, 1'b1, 21'd3, 1'b1, 1'b1), 1, 0, lat);
    run_op(mk_op(4'd0, 5'd0, 5'd3, 1'b1, 21'd5, 1'b1, 1'b1), 1, 0, lat);
    run_op(mk_op(4'd1, 5'd2, 5'd3, 1'b0, 21'd0, 1'b0, 1'b0), 1, 0, lat);
    check_eq("sub_borrow_result", alu_result, 32'hFFFF_FFFE);
    check_eq("sub_borrow_flags", {zero_flag, carry_flag, sign_flag, overflow_flag}, 4'b0110);
    run_op(mk_op(4'd1, 5'd2, 5'd2, 1'b0, 21'd0, 1'b0, 1'b0), 1, 0, lat);
    check_eq("sub_equal_flags", {zero_flag, carry_flag, sign_flag, overflow_flag}, 4'b1000);
    // r4 = -1 (sign-extended immediate), MUL r4 * 2
    run_op(mk_op(4'd0, 5'd0, 5'd4, 1'b1, 21'h1F_FFFF, 1'b1, 1'b1), 1, 0, lat);
    run_op(mk_op(4'd9, 5'd4, 5'd0, 1'b1, 21'd2, 1'b1, 1'b0), 1, 0, lat);
    check_eq("mul_low", alu_result, 32'hFFFF_FFFE);
    check_eq("mul_high", mult_high, 32'h1);
    check_eq("mul_carry", carry_flag, 1'b1);
    check_eq("mul_lat", lat, 35);
    // Slow load into r5, then read it back through the ALU
    o = mk_op(4'd0, 5'd0, 5'd5, 1'b1, 21'h100, 1'b1, 1'b1); o.mr = 1'b1; o.rsel = 1'b0;
    run_op(o, 4, 32'hDEAD_BEEF, lat);
    check_eq("load_slow_lat", lat, 7);
    run_op(mk_op(4'd0, 5'd5, 5'd0, 1'b1, 21'd0, 1'b0, 1'b0), 1, 0, lat);
    check_eq("load_readback", alu_result, 32'hDEAD_BEEF);
    // Store of r3 to address r1+8
    o = mk_op(4'd0, 5'd1, 5'd3, 1'b1, 21'd8, 1'b1, 1'b0); o.mw = 1'b1;
    run_op(o, 2, 32'h1234_5678, lat);
    // Link writes npc to r31
    o = mk_op(4'd2, 5'd0, 5'd0, 1'b0, 21'd0, 1'b0, 1'b0); o.link = 1'b1; o.npc = 32'h40;
    run_op(o, 1, 0, lat);
    check_eq("link_dest", write_address, 5'd31);
    run_op(mk_op(4'd0, 5'd31, 5'd0, 1'b1, 21'd0, 1'b0, 1'b0), 1, 0, lat);
    check_eq("link_readback", alu_result, 32'h40);

    // Reset in the middle of a MUL that would write r6
    @(negedge clk);
    drive(mk_op(4'd9, 5'd1, 5'd6, 1'b1, 21'd7, 1'b1, 1'b1));
    start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      start = 1'b0;
      check_eq("midmul_no_done", done, 1'b0);
    end
    rst = 1'b1;
    @(negedge clk);
    check_eq("midmul_ready", ready, 1'b1);
    check_eq("midmul_mult_high", mult_high, 0);
    check_eq("midmul_done", done, 1'b0);
    check_eq("midmul_mem_req", mem_req, 1'b0);
    rst = 1'b0;
    model_reset();
    run_op(mk_op(4'd0, 5'd6, 5'd0, 1'b1, 21'd0, 1'b0, 1'b0), 1, 0, lat);
    check_eq("midmul_dest_unchanged", alu_result, 0);

    // Random operations against the reference model
    for (int n = 0; n < 200; n++) begin
      o = op_t'({$urandom, $urandom, $urandom});
      o.op = ($urandom_range(0, 4) == 0) ? 4'd9 : 4'($urandom_range(0, 15));
      o.mr = ($urandom_range(0, 4) == 0);
      o.mw = ($urandom_range(0, 5) == 0);
      o.link = ($urandom_range(0, 9) == 0);
      if (!(o.mr && !o.mw)) o.rsel = 1'b1;
      run_op(o, $urandom_range(1, 5), $urandom, lat);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
